muldiv_unit: RTL and testbench

Iterative MIPS multiply/divide unit with the architectural HI/LO registers, implementing MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits directly downstream of the register file. Its operands come from read ports 1 and 2 (rs/rt), and HI/LO feed back to the register-file write data path through the MFHI/MFLO mux. Each operation takes a fixed 33 cycles, and a `busy` flag lets the controller stall MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_negate.sv | 12 +
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the fixed iteration count.
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement: y = en ? -a : a.
module muldiv_negate #(
  parameter int DATA_W = 32
) (
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] y
);

  assign y = en ? (~a + DATA_W'(1)) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Define MULDIV_DISPLAY_EN to compile in a $display trace of results and HI/LO writes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [32:0]        hi_w;
  logic [31:0]        lo_w, opnd, rs_cap;
  logic [1:0]         op_r;
  logic               sign_q, sign_r, div_zero;

  logic               rs_neg_en, rt_neg_en;
  logic [31:0]        rs_mag, rt_mag, quo_fix, rem_fix;
  logic [63:0]        prod_fix;
  logic [32:0]        add_sum, shifted, trial;
  logic               fits;
  logic [31:0]        res_hi, res_lo;

  // Launch: signed ops work on magnitudes
  assign rs_neg_en = ~op[0] & rs_val[31];
  assign rt_neg_en = ~op[0] & rt_val[31];

  muldiv_negate #(.DATA_W(32)) u_neg_rs (.en(rs_neg_en), .a(rs_val), .y(rs_mag));
  muldiv_negate #(.DATA_W(32)) u_neg_rt (.en(rt_neg_en), .a(rt_val), .y(rt_mag));

  // Iteration: shift-add multiply step and restoring divide step
  assign add_sum = {1'b0, hi_w[31:0]} + {1'b0, opnd};
  assign shifted = {hi_w[31:0], lo_w[31]};
  assign fits    = shifted >= {1'b0, opnd};
  assign trial   = shifted - {1'b0, opnd};

  // Fixup: reapply recorded signs to the magnitude results
  muldiv_negate #(.DATA_W(64)) u_neg_prod (.en(sign_q), .a({hi_w[31:0], lo_w}), .y(prod_fix));
  muldiv_negate #(.DATA_W(32)) u_neg_quo  (.en(sign_q), .a(lo_w),              .y(quo_fix));
  muldiv_negate #(.DATA_W(32)) u_neg_rem  (.en(sign_r), .a(hi_w[31:0]),        .y(rem_fix));

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (op_r[1]) begin
      if (div_zero) begin
        res_hi = rs_cap;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == CNT_W'(ITER - 1)) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      hi_w     <= '0;
      lo_w     <= '0;
      opnd     <= '0;
      rs_cap   <= '0;
      op_r     <= OP_MULT;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r     <= op;
            cnt      <= '0;
            hi_w     <= '0;
            lo_w     <= op[1] ? rs_mag : rt_mag;
            opnd     <= op[1] ? rt_mag : rs_mag;
            sign_q   <= ~op[0] & (rs_val[31] ^ rt_val[31]);
            sign_r   <= ~op[0] & rs_val[31];
            div_zero <= (rt_val == 32'd0);
            rs_cap   <= rs_val;
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_r[1]) begin
            hi_w <= fits ? trial : shifted;
            lo_w <= {lo_w[30:0], fits};
          end else if (lo_w[0]) begin
            hi_w <= {1'b0, add_sum[32:1]};
            lo_w <= {add_sum[0], lo_w[31:1]};
          end else begin
            hi_w <= {2'b00, hi_w[31:1]};
            lo_w <= {hi_w[0], lo_w[31:1]};
          end
        end
        S_FIXUP: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DISPLAY_EN
  logic [31:0] rt_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rt_cap <= '0;
    else if (state == S_IDLE && start) rt_cap <= rt_val;
  end

  function automatic string op_name(input logic [1:0] o);
    case (o)
      OP_MULT:  return "MULT";
      OP_MULTU: return "MULTU";
      OP_DIV:   return "DIV";
      default:  return "DIVU";
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n && state == S_FIXUP)
      $display("%0t: %s rs=%0d rt=%0d -> HI=%0d LO=%0d",
               $time, op_name(op_r), rs_cap, rt_cap, res_hi, res_lo);
    if (rst_n && state == S_IDLE && !start && hi_we)
      $display("%0t: MTHI HI=%0d", $time, wd);
    if (rst_n && state == S_IDLE && !start && lo_we)
      $display("%0t: MTLO LO=%0d", $time, wd);
  end
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with a cycle-level reference model and
// hand-computed HI/LO expectations.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0, wd = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
    .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference: architectural result from plain 64-bit arithmetic
  function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] pend = '0;
  int          remaining = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_hi      <= '0;
      m_lo      <= '0;
      remaining <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= pend[63:32];
          m_lo   <= pend[31:0];
        end
      end else if (start) begin
        pend      <= model_result(op, rs_val, rt_val);
        m_busy    <= 1'b1;
        remaining <= 33;
      end else begin
        if (hi_we) m_hi <= wd;
        if (lo_we) m_lo <= wd;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", 32'(busy), 32'(m_busy));
      check("model done", 32'(done), 32'(m_done));
      check("model hi", hi, m_hi);
      check("model lo", lo, m_lo);
      check("busy&done exclusive", 32'(busy & done), 32'd0);
    end
  end

  task automatic wait_done(output int nb, output bit seen);
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int nb;
    bit seen;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
    wait_done(nb, seen);
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " busy cycles"}, nb, 32'd33);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
  endtask

  initial begin
    int nb;
    bit seen;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    hi_we = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wd = 32'h0000_5678;
    check("mthi", hi, 32'h0000_1234);
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo, 32'h0000_5678);

    run_op("mult -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    run_op("mult 80000000*2", 2'b00, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'd0);

    // start and MTHI in the same idle cycle: start wins
    hi_we = 1'b1; wd = 32'h0000_BEEF;
    run_op("multu 1*1 with mthi", 2'b01, 32'd1, 32'd1, 32'd0, 32'd1);

    @(negedge clk);
    hi_we = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi again", hi, 32'h0000_1234);

    // start and MTLO while busy are both dropped
    op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; rs_val = 32'd99; rt_val = 32'd7;
    lo_we = 1'b1; wd = 32'h0000_AAAA;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    wait_done(nb, seen);
    check("busy ignore done seen", 32'(seen), 32'd1);
    check("busy ignore hi", hi, 32'd0);
    check("busy ignore lo", lo, 32'd6);
    @(negedge clk);
    check("no second op", 32'(busy), 32'd0);

    // asynchronous reset mid-CALC
    op = 2'b00; rs_val = 32'd1000; rt_val = 32'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst hi", hi, 32'd0);
    check("async rst lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mult 4*5 after reset", 2'b00, 32'd4, 32'd5, 32'd0, 32'd20);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
